// File: rtl/sd_dev_data_tx_ctrl.sv
// sd_dev_data_tx_ctrl: SD 4-bit data-line transmit sequencer (start nibble, data, per-line CRC16, end nibble)
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   i_phy_stb       one-clk pulse per SD clock period (byte-slot boundary)
//   i_start/i_abort begin a block (IDLE only) / terminate immediately
//   i_block_len     block length in bytes, latched on start
//   i_data, i_data_valid, o_data_ready   read-data source handshake
//   o_sd_data_dir, o_sd_data_out        registered PHY drive enable and byte slot
//   o_busy, o_done, o_underrun          status
module sd_dev_data_tx_ctrl #(
   parameter int LEN_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_phy_stb,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [LEN_WIDTH-1:0] i_block_len,
   input  logic [7:0]           i_data,
   input  logic                 i_data_valid,
   output logic                 o_data_ready,
   output logic                 o_sd_data_dir,
   output logic [7:0]           o_sd_data_out,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_underrun
);
   typedef enum logic [2:0] {IDLE, PRE, DATA, CRC, END} state_t;
   state_t               state;
   logic [LEN_WIDTH-1:0] rem;
   logic [2:0]           slot;
   logic [3:0][15:0]     crc, crc_nxt;
   logic [7:0]           tx_byte;
   logic [3:0]           crc_hi, crc_lo;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
   endfunction

   assign o_data_ready = i_phy_stb && state == DATA;
   assign tx_byte      = i_data_valid ? i_data : 8'h00;

   // Line k carries bit 4+k in the first nibble and bit k in the second.
   // During CRC slots each register is shifted left by two, so the two
   // MSBs always hold the next pair of check bits.
   for (genvar k = 0; k < 4; k++) begin : g_line
      assign crc_nxt[k] = crc_step(crc_step(crc[k], tx_byte[4+k]), tx_byte[k]);
      assign crc_hi[k]  = crc[k][15];
      assign crc_lo[k]  = crc[k][14];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rem           <= '0;
         slot          <= '0;
         crc           <= '0;
         o_sd_data_dir <= 1'b0;
         o_sd_data_out <= 8'hFF;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_underrun    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (state != IDLE && i_abort) begin
            state         <= IDLE;
            slot          <= '0;
            o_sd_data_dir <= 1'b0;
            o_sd_data_out <= 8'hFF;
            o_busy        <= 1'b0;
         end else begin
            case (state)
               IDLE: if (i_start && !i_abort && i_block_len != '0) begin
                  rem        <= i_block_len;
                  crc        <= '0;
                  o_underrun <= 1'b0;
                  o_busy     <= 1'b1;
                  state      <= PRE;
               end
               PRE: if (i_phy_stb) begin
                  o_sd_data_out <= 8'hF0;
                  o_sd_data_dir <= 1'b1;
                  state         <= DATA;
               end
               DATA: if (i_phy_stb) begin
                  o_sd_data_out <= tx_byte;
                  crc           <= crc_nxt;
                  rem           <= rem - 1'b1;
                  if (!i_data_valid) o_underrun <= 1'b1;
                  if (rem == LEN_WIDTH'(1)) begin
                     state <= CRC;
                     slot  <= '0;
                  end
               end
               CRC: if (i_phy_stb) begin
                  o_sd_data_out <= {crc_hi, crc_lo};
                  for (int i = 0; i < 4; i++) crc[i] <= {crc[i][13:0], 2'b00};
                  slot <= slot + 1'b1;
                  if (slot == 3'd7) state <= END;
               end
               // slot 0: end nibble slot; slot 1: release the lines
               END: if (i_phy_stb) begin
                  o_sd_data_out <= 8'hFF;
                  if (slot == 3'd0) slot <= 3'd1;
                  else begin
                     slot          <= '0;
                     o_sd_data_dir <= 1'b0;
                     o_done        <= 1'b1;
                     o_busy        <= 1'b0;
                     state         <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
